bist_pattern_driver: RTL and testbench

Built-in self-test driver for the small combinational benchmark netlists in this codebase: it generates pseudo-random input vectors for a circuit under test (CUT) and compacts the CUT's outputs into a signature. It is the stimulus and response end of a netlist's primary-input/primary-output interface. It sits beside one CUT instance: its `pattern` output drives the CUT inputs, and the CUT outputs return on `response`. A single start/done handshake runs one test, and the pass/fail verdict is taken by comparing the signature with a golden value.

---
 rtl/bist_pkg.sv | 30 +++
 rtl/bist_misr.sv | 34 +++
 rtl/bist_pattern_driver.sv | 116 +++++++++++
 tb/tb_bist_pattern_driver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types, tap constants and next-state functions for the BIST pattern driver.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_e;

  // x^5+x^3+1 for the stimulus LFSR, x^8+x^6+x^5+x^4+1 for the MISR.
  localparam logic [4:0] LFSR_TAPS = 5'b10100;
  localparam logic [7:0] MISR_TAPS = 8'b10111000;

  // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] p,
                                            input logic [31:0] taps,
                                            input int          w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((p << 1) | {31'd0, ^(p & taps)}) & mask;
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] m,
                                            input logic [31:0] taps,
                                            input logic [31:0] rsp,
                                            input int          w);
    return lfsr_next(m, taps, w) ^ rsp;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting CUT responses.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               SIG_W = 8,
  parameter int               RSP_W = 2,
  parameter logic [SIG_W-1:0] TAPS  = SIG_W'(MISR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [RSP_W-1:0] response,
  output logic [SIG_W-1:0] signature
);

  logic [SIG_W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = SIG_W'(misr_next(32'(signature), 32'(TAPS), 32'(response), SIG_W));
  end

  // clear wins over enable so a start or abort always leaves a clean register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (enable) begin
      signature <= sig_nxt;
    end
  end

endmodule

// File: rtl/bist_pattern_driver.sv
// BIST driver: LFSR stimulus to the CUT, MISR compaction of its responses, pass/fail verdict.
module bist_pattern_driver
  import bist_pkg::*;
#(
  parameter int               PAT_W    = 5,
  parameter int               RSP_W    = 2,
  parameter int               SIG_W    = 8,
  parameter int               NUM_PAT  = 31,
  parameter logic [PAT_W-1:0] SEED     = 5'b00001,
  parameter logic [SIG_W-1:0] GOLDEN   = 8'h00,
  parameter logic [PAT_W-1:0] PAT_TAPS = PAT_W'(LFSR_TAPS),
  parameter logic [SIG_W-1:0] SIG_TAPS = SIG_W'(MISR_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [RSP_W-1:0] response,
  output logic [PAT_W-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output bist_state_e      dbg_state
);

  // Handshake: start (with abort low) is taken in IDLE or DONE and ignored in RUN;
  // busy is high for the whole run, done/pass/signature hold until the next accepted start.

  localparam int CNT_W = $clog2(NUM_PAT + 1);

  bist_state_e      state;
  logic [CNT_W-1:0] count;
  logic [PAT_W-1:0] pat_nxt;
  logic [SIG_W-1:0] sig_nxt;
  logic             last;
  logic             accept;
  logic             misr_clear;
  logic             misr_en;

  always_comb begin
    pat_nxt    = PAT_W'(lfsr_next(32'(pattern), 32'(PAT_TAPS), PAT_W));
    sig_nxt    = SIG_W'(misr_next(32'(signature), 32'(SIG_TAPS), 32'(response), SIG_W));
    last       = (count == CNT_W'(NUM_PAT - 1));
    accept     = (state != RUN) && start && !abort;
    misr_clear = accept || ((state == RUN) && abort);
    misr_en    = (state == RUN) && !abort;
  end

  assign dbg_state = state;

  bist_misr #(
    .SIG_W (SIG_W),
    .RSP_W (RSP_W),
    .TAPS  (SIG_TAPS)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (misr_clear),
    .enable    (misr_en),
    .response  (response),
    .signature (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pattern <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= RUN;
            pattern <= SEED;
            count   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            pattern <= '0;
            count   <= '0;
            busy    <= 1'b0;
          end else begin
            count <= count + 1'b1;
            if (last) begin
              // Verdict uses the signature after the final response is absorbed.
              state   <= DONE;
              pattern <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (sig_nxt == GOLDEN);
            end else begin
              pattern <= pat_nxt;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pattern <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Directed bench for bist_pattern_driver: vector table plus hand-written multi-cycle sequences.
module tb_bist_pattern_driver;
  import bist_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n, start, abort, start3, resp_mode;
  always #5 clk = ~clk;

  logic [4:0]  pattern;
  logic [1:0]  response;
  logic        busy, done, pass;
  logic [7:0]  signature;
  bist_state_e dbg_state;

  logic [4:0]  pattern_a, pattern_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0]  sig_a, sig_b;
  bist_state_e st_a, st_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  // Independent reference of the CUT, LFSR and MISR.
  function automatic logic [1:0] cut_f(input logic [4:0] p);
    return {p[4] ^ p[1], p[0] & p[3]};
  endfunction

  function automatic logic [4:0] m_lfsr(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction

  function automatic logic [7:0] m_misr(input logic [7:0] m, input logic [1:0] r);
    logic fb;
    fb = m[7] ^ m[5] ^ m[4] ^ m[3];
    return {m[6:0], fb} ^ {6'b000000, r};
  endfunction

  assign response = resp_mode ? cut_f(pattern) : 2'b00;

  bist_pattern_driver #(
    .NUM_PAT (31), .SEED (5'h01), .GOLDEN (8'h00)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .response (response), .pattern (pattern), .busy (busy), .done (done),
    .pass (pass), .signature (signature), .dbg_state (dbg_state)
  );

  bist_pattern_driver #(
    .NUM_PAT (3), .SEED (5'h01), .GOLDEN (8'h00)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start3), .abort (1'b0),
    .response (2'b01), .pattern (pattern_a), .busy (busy_a), .done (done_a),
    .pass (pass_a), .signature (sig_a), .dbg_state (st_a)
  );

  bist_pattern_driver #(
    .NUM_PAT (3), .SEED (5'h01), .GOLDEN (8'h07)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start3), .abort (1'b0),
    .response (2'b01), .pattern (pattern_b), .busy (busy_b), .done (done_b),
    .pass (pass_b), .signature (sig_b), .dbg_state (st_b)
  );

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_pattern"},   32'(pattern),   32'h0);
    check({tag, "_signature"}, 32'(signature), 32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
    check({tag, "_done"},      32'(done),      32'h0);
    check({tag, "_pass"},      32'(pass),      32'h0);
    check({tag, "_state"},     32'(dbg_state), 32'(IDLE));
  endtask

  // Fills exp_q with the 31 expected patterns and returns the expected signature.
  task automatic model_run(output logic [7:0] sig);
    logic [4:0] p;
    logic [7:0] m;
    p = 5'h01;
    m = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 31; i++) begin
      exp_q.push_back(p);
      m = m_misr(m, resp_mode ? cut_f(p) : 2'b00);
      p = m_lfsr(p);
    end
    sig = m;
  endtask

  // start is high on edges 0..hold-1 and on edge pulse_at (edge 0 is the accepting edge).
  task automatic run_full(input int hold, input int pulse_at, input string tag);
    logic [7:0] esig;
    int cycles;
    model_run(esig);
    start = 1'b1;
    step();
    check({tag, "_busy0"}, 32'(busy), 32'h1);
    check({tag, "_done0"}, 32'(done), 32'h0);
    check({tag, "_pat0"},  32'(pattern), 32'(exp_q.pop_front()));
    cycles = 0;
    while (!done && cycles < 200) begin
      start = ((cycles + 1) < hold) || ((cycles + 1) == pulse_at);
      step();
      cycles++;
      if (busy && exp_q.size() > 0) check({tag, "_pat"}, 32'(pattern), 32'(exp_q.pop_front()));
    end
    start = 1'b0;
    check({tag, "_latency"},   32'(cycles),         32'd31);
    check({tag, "_all_pats"},  32'(exp_q.size()),   32'd0);
    check({tag, "_signature"}, 32'(signature),      32'(esig));
    check({tag, "_pass"},      32'(pass),           32'(esig == 8'h00));
    check({tag, "_pat_done"},  32'(pattern),        32'h0);
    check({tag, "_busy_done"}, 32'(busy),           32'h0);
    check({tag, "_state"},     32'(dbg_state),      32'(DONE));
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic [4:0] pat;
    logic       busy;
    logic       done;
    logic [7:0] sig;
  } vec_t;

  vec_t vecs[10];

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 5'h02, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 5'h04, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 5'h09, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 5'h12, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 5'h05, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 5'h00, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 5'h00, 1'b0, 1'b0, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b0, 8'h00};
    vecs[9] = '{1'b1, 1'b1, 5'h00, 1'b0, 1'b0, 8'h00};

    resp_mode = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    start3    = 1'b0;
    rst_n     = 1'b0;
    #12;
    check_idle_zero("por");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      step();
      check($sformatf("vec%0d_pattern", i), 32'(pattern),   32'(vecs[i].pat));
      check($sformatf("vec%0d_busy", i),    32'(busy),      32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i),    32'(done),      32'(vecs[i].done));
      check($sformatf("vec%0d_sig", i),     32'(signature), 32'(vecs[i].sig));
    end
    start = 1'b0;
    abort = 1'b0;
    step();

    // Zero response over a full run, then a data-dependent CUT.
    run_full(1, 0, "zero");
    resp_mode = 1'b1;
    run_full(1, 0, "cut");
    run_full(3, 0, "done_hold");
    run_full(1, 7, "pulse");

    // Abort after 10 RUN cycles, then start+abort together in IDLE.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("abort_busy_before", 32'(busy), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle_zero("abort");
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle_zero("start_abort_idle");
    step();
    check("start_abort_idle_later", 32'(dbg_state), 32'(IDLE));
    run_full(1, 0, "after_abort");

    // Abort in DONE has no effect.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_done_state", 32'(dbg_state), 32'(DONE));
    check("abort_in_done_done",  32'(done),      32'h1);

    // Asynchronous reset between edges mid-run.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async");
    #1;
    rst_n = 1'b1;
    step();
    run_full(1, 0, "after_reset");

    // Constant 01 response with NUM_PAT=3 against two goldens.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("small_pat0",  32'(pattern_a), 32'h01);
    check("small_busy0", 32'(busy_a),    32'h1);
    step();
    step();
    check("small_done_early", 32'(done_a), 32'h0);
    step();
    check("small_done_a", 32'(done_a), 32'h1);
    check("small_sig_a",  32'(sig_a),  32'h07);
    check("small_pass_a", 32'(pass_a), 32'h0);
    check("small_done_b", 32'(done_b), 32'h1);
    check("small_sig_b",  32'(sig_b),  32'h07);
    check("small_pass_b", 32'(pass_b), 32'h1);
    check("small_busy_b", 32'(busy_b), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
